// File: rtl/aether_engine_mem_arbiter.sv
// aether_engine_mem_arbiter
// Two-port round-robin arbiter in front of a single task-based memory engine.
// A winning port's command and address range are latched. The command is
// issued to memory for one cycle. The task is then supervised until memory
// reports completion or a cycle budget expires. Bad requests are refused
// without touching memory.
module aether_engine_mem_arbiter #(
  parameter int TimeoutCycles = 200_000,
  parameter int ClkRate       = 143_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  input  logic [1:0][1:0]  req_cmd_i,
  input  logic [1:0][31:0] req_start_i,
  input  logic [1:0][31:0] req_end_i,
  input  logic [1:0]       req_en_i,
  input  logic [1:0][15:0] req_data_write_i,
  output logic [1:0]       req_ready_o,
  output logic [1:0]       req_done_o,
  output logic [1:0]       req_err_o,
  output logic [1:0][15:0] req_data_read_o,
  output logic [1:0]       req_data_read_valid_o,
  output logic [1:0]       req_data_write_ready_o,
  output logic [1:0]       mem_command_o,
  output logic [31:0]      mem_start_o,
  output logic [31:0]      mem_end_o,
  output logic             mem_en_o,
  output logic             mem_rst_o,
  output logic [15:0]      mem_data_write_o,
  input  logic [15:0]      mem_data_read_i,
  input  logic             mem_data_read_valid_i,
  input  logic             mem_data_write_ready_i,
  input  logic             mem_task_finished_i,
  input  logic             mem_running_i,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int NumPorts = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_REJECT = 2'd3;

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_BAD  = 2'd3;

  // Last RUN cycle index before the task is declared hung.
  localparam logic [31:0] LastCnt = 32'(TimeoutCycles - 1);

  // Clock rate is carried for documentation of the instantiating system only.
  localparam int unused_clk_rate = ClkRate;

  logic [1:0]  state;
  logic        owner;
  logic        last;
  logic        armed;
  logic        timeout_q;
  logic [1:0]  cmd_q;
  logic [31:0] start_q;
  logic [31:0] end_q;
  logic [31:0] cnt;

  logic        any_req;
  logic        winner;
  logic        bad_req;
  logic        select;
  logic        active;
  logic        armed_now;
  logic        finish;
  logic        expire;

  // Arbitration and task-supervision decode, all qualified by reset so that
  // outputs collapse to zero while rst_i is high.
  always_comb begin
    any_req = |req_valid_i;
    // On contention the port that did not complete last goes next;
    // otherwise whichever single port asks wins.
    if (&req_valid_i) winner = ~last;
    else              winner = req_valid_i[1];
    bad_req = (req_cmd_i[winner] == CMD_IDLE) ||
              (req_cmd_i[winner] == CMD_BAD)  ||
              (req_end_i[winner] < req_start_i[winner]);
    select  = !rst_i && (state == S_IDLE) && any_req;
    active  = !rst_i && ((state == S_ISSUE) || (state == S_RUN));
    // The running flag arms completion detection on the cycle it is seen.
    armed_now = armed | mem_running_i;
    finish  = !rst_i && (state == S_RUN) && armed_now && mem_task_finished_i;
    // A completion on the last budgeted cycle still counts as success.
    expire  = !rst_i && (state == S_RUN) && !finish && (cnt == LastCnt);
  end

  // State, latched request and supervision counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      armed     <= 1'b0;
      timeout_q <= 1'b0;
      cmd_q     <= 2'd0;
      start_q   <= 32'd0;
      end_q     <= 32'd0;
      cnt       <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner   <= winner;
            cmd_q   <= req_cmd_i[winner];
            start_q <= req_start_i[winner];
            end_q   <= req_end_i[winner];
            state   <= bad_req ? S_REJECT : S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= 32'd0;
          armed <= 1'b0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (finish) begin
            last  <= owner;
            state <= S_IDLE;
          end else if (expire) begin
            timeout_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
            if (mem_running_i) armed <= 1'b1;
          end
        end
        S_REJECT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Handshake pulses and the memory-facing command side.
  always_comb begin
    req_ready_o      = '0;
    req_done_o       = '0;
    req_err_o        = '0;
    mem_command_o    = 2'd0;
    mem_start_o      = 32'd0;
    mem_end_o        = 32'd0;
    mem_en_o         = 1'b0;
    mem_data_write_o = 16'd0;
    busy_o           = 1'b0;
    timeout_o        = 1'b0;
    mem_rst_o        = 1'b1;
    if (!rst_i) begin
      mem_rst_o   = expire;
      busy_o      = (state != S_IDLE);
      timeout_o   = timeout_q;
      mem_start_o = start_q;
      mem_end_o   = end_q;
      if (select) req_ready_o[winner] = 1'b1;
      if (state == S_REJECT) begin
        req_done_o[owner] = 1'b1;
        req_err_o[owner]  = 1'b1;
      end
      if (finish) req_done_o[owner] = 1'b1;
      if (expire) begin
        req_done_o[owner] = 1'b1;
        req_err_o[owner]  = 1'b1;
      end
      if (state == S_ISSUE) mem_command_o = cmd_q;
      if (active) begin
        mem_en_o         = req_en_i[owner];
        mem_data_write_o = req_data_write_i[owner];
      end
    end
  end

  // Per-lane return path: only the owning lane sees memory data and strobes.
  for (genvar p = 0; p < NumPorts; p++) begin : g_lane
    logic lane_sel;
    assign lane_sel                  = active && (owner == 1'(p));
    assign req_data_read_o[p]        = lane_sel ? mem_data_read_i : 16'd0;
    assign req_data_read_valid_o[p]  = lane_sel & mem_data_read_valid_i;
    assign req_data_write_ready_o[p] = lane_sel & mem_data_write_ready_i;
  end

endmodule

// File: doc/aether_engine_mem_arbiter.md
AETHER_ENGINE_MEM_ARBITER -- requirements
Module: aether_engine_mem_arbiter

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 200_000, RUN-state cycle limit before abort.
REQ-002 SHALL have parameter ClkRate, default 143_000_000, passed through for documentation only.
REQ-003 clk_i  in  1  single clock; all logic on posedge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 req_valid_i  in  [1:0]  per-port task request (port p = bit p).
REQ-006 req_cmd_i  in  [1:0][1:0]  per-port command; 0 IDLE, 1 WRITE, 2 READ.
REQ-007 req_start_i / req_end_i  in  [1:0][31:0]  per-port inclusive address range.
REQ-008 req_en_i  in  [1:0]  per-port write-advance enable.
REQ-009 req_data_write_i  in  [1:0][15:0]  per-port write data.
REQ-010 req_ready_o  out  [1:0]  one-cycle grant/accept pulse.
REQ-011 req_done_o  out  [1:0]  one-cycle task-complete pulse.
REQ-012 req_err_o  out  [1:0]  valid with req_done_o; 1 = rejected or timed out.
REQ-013 req_data_read_o  out  [1:0][15:0], req_data_read_valid_o  out  [1:0], req_data_write_ready_o  out  [1:0]  routed memory data.
REQ-014 mem_command_o  out  2; mem_start_o / mem_end_o  out  32; mem_en_o  out  1; mem_rst_o  out  1; mem_data_write_o  out  16  toward memory.
REQ-015 mem_data_read_i  in  16; mem_data_read_valid_i, mem_data_write_ready_i, mem_task_finished_i, mem_running_i  in  1  from memory.
REQ-016 busy_o  out  1  high in any state but IDLE; timeout_o  out  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RUN, REJECT.
REQ-018 IDLE: when any req_valid_i is high, SHALL select a winner round-robin: the port not last granted wins on contention; after reset port 0 has priority.
REQ-019 On selection SHALL latch winner index, cmd, start and end, pulse req_ready_o[winner] for one cycle, and change state on the next edge.
REQ-020 A latched cmd of IDLE or 3, or end < start, SHALL go to REJECT; otherwise to ISSUE.
REQ-021 REJECT SHALL last one cycle: pulse req_done_o and req_err_o for the owner, issue no memory command, then return to IDLE.
REQ-022 ISSUE SHALL drive mem_command_o = latched cmd, mem_start_o/mem_end_o = latched range for exactly one cycle, then go to RUN.
REQ-023 mem_command_o SHALL be 0 in every state other than ISSUE; mem_start_o/mem_end_o SHALL hold latched values outside IDLE.
REQ-024 RUN SHALL arm completion detection when mem_running_i is first seen high; mem_task_finished_i SHALL be ignored while disarmed and in all other states.
REQ-025 RUN: armed and mem_task_finished_i high SHALL pulse req_done_o[owner] with req_err_o low, update last-granted to owner, and return to IDLE.
REQ-026 RUN SHALL count cycles from 0; on reaching TimeoutCycles-1 without completion SHALL pulse req_done_o and req_err_o, pulse mem_rst_o for one cycle, set timeout_o, and return to IDLE.
REQ-027 Outside ISSUE/RUN, mem_en_o SHALL be 0 and mem_data_write_o 0; in ISSUE/RUN they SHALL equal the owner's req_en_i and req_data_write_i.
REQ-028 In ISSUE/RUN, req_data_read_o, req_data_read_valid_o and req_data_write_ready_o SHALL be routed to the owner only; non-owner lanes and all lanes in other states SHALL be 0.
REQ-029 req_valid_i SHALL be ignored outside IDLE; requests held high SHALL be served after the current task completes.
REQ-030 At most one bit of req_ready_o and at most one bit of req_done_o SHALL be high in any cycle.

Reset
REQ-031 rst_i SHALL force IDLE, last-granted = port 1 so port 0 wins first, and clear the counter, armed flag and timeout_o.
REQ-032 During rst_i all outputs SHALL be 0 except mem_rst_o, which SHALL be 1.
REQ-033 Reset mid-task SHALL abandon the task with no req_done_o pulse.

Verification
REQ-034 Port 0 READ 0..3 alone -> ready[0] pulse, command=2 for one cycle, 4 read_valid on lane 0 only, done[0] with err=0.
REQ-035 Both ports request WRITE on the same cycle after reset -> port 0 granted first, then port 1; with both held, grants alternate 0,1,0,1.
REQ-036 Port 1 cmd=3, and separately start=10 end=5 -> ready[1] then done[1]+err[1] next cycle; mem_command_o stays 0.
REQ-037 TimeoutCycles=16, memory never finishes -> done+err on cycle 16 of RUN, mem_rst_o one-cycle pulse, timeout_o stays 1 until rst_i.
REQ-038 rst_i asserted in RUN -> next cycle IDLE, no done pulse, mem_rst_o high during reset, then a new request is accepted normally.
